instr_fetch: RTL and testbench

Instruction fetch unit driving the `instr` input of the `riscv` core from an instruction memory port. It holds the fetch PC and issues in-order word reads with a request/grant, variable-latency response protocol. Returned words are buffered in a small prefetch FIFO and handed to the core's decode stage over a valid/ready handshake. A redirect from the core (branch/jump) flushes the FIFO and discards stale in-flight responses.

---
 rtl/instr_fetch.sv | 105 ++++++++++
 tb/tb_instr_fetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, credit-limited memory requests,
// prefetch FIFO toward decode, redirect flush with stale-response discard.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [31:0]   r_data [DEPTH];
  logic [31:0]   r_pc   [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_discard;

  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_gnt;
  logic [CW:0]   w_inflight;
  logic [CW-1:0] w_out_nxt;

  assign instr_valid = (r_count != '0);
  assign instr       = r_data[r_rd_ptr];
  assign instr_pc    = r_pc[r_rd_ptr];
  assign mem_addr    = r_fetch_pc;

  assign w_pop = instr_valid && instr_ready;

  // A head leaving this cycle frees its slot, keeping one fetch per cycle.
  assign w_inflight = {1'b0, r_outst} + {1'b0, r_count}
                    - {{CW{1'b0}}, w_pop};

  assign mem_req = reset && !redirect
                && (w_inflight < (CW+1)'(DEPTH));

  assign w_gnt  = mem_req && mem_gnt;
  assign w_drop = mem_rvalid && (r_discard != '0);
  assign w_push = mem_rvalid && (r_discard == '0) && !redirect;

  assign w_out_nxt = r_outst + CW'(w_gnt) - CW'(mem_rvalid);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_outst    <= '0;
      r_discard  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= RESET_PC;
      end
    end else begin
      r_outst <= w_out_nxt;
      if (redirect) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
        r_resp_pc  <= {redirect_pc[31:2], 2'b00};
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
        r_discard  <= w_out_nxt;
      end else begin
        if (w_gnt) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_drop) begin
          r_discard <= r_discard - CW'(1);
        end
        if (w_push) begin
          r_data[r_wr_ptr] <= mem_rdata;
          r_pc[r_wr_ptr]   <= r_resp_pc;
          r_wr_ptr         <= r_wr_ptr + AW'(1);
          r_resp_pc        <= r_resp_pc + 32'd4;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: memory model with
// variable latency, queue of granted fetches, decoupled pop monitor.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        instr_ready = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  exp_t  exp_q[$];
  pend_t pend_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_due = 0;
  int pops = 0;
  int grants = 0;
  int gnt_pct = 100;
  int rdy_pct = 100;
  int lat_min = 1;
  int lat_max = 1;
  logic [31:0] fexp = RST_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16]} + 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares every consumed instruction with the scoreboard.
  logic        prev_rst = 1'b1;
  logic        prev_redir = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_ins = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) chk1("req_in_reset", mem_req, 1'b0);
    if (!prev_rst) begin
      chk1("rst_valid", instr_valid, 1'b0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, RST_PC);
      chk("rst_mem_addr", mem_addr, RST_PC);
    end else begin
      if (prev_redir) chk1("valid_after_redirect", instr_valid, 1'b0);
      if (prev_hold) begin
        chk1("hold_valid", instr_valid, 1'b1);
        chk("hold_pc", instr_pc, prev_pc);
        chk("hold_instr", instr, prev_ins);
      end
    end
    if (reset && instr_valid && instr_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc %h expected none (cycle %0d)",
                 instr_pc, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", instr_pc, e.pc);
        chk("pop_instr", instr, e.data);
      end
    end
    prev_rst   = reset;
    prev_redir = reset && redirect;
    prev_hold  = reset && !redirect && instr_valid && !instr_ready;
    prev_pc    = instr_pc;
    prev_ins   = instr;
  end

  // One clock of stimulus plus memory model and scoreboard pushes.
  task automatic cycle(input logic rst, input logic rd,
                       input logic [31:0] rpc);
    pend_t p;
    int    lat;
    int    due;
    @(posedge clk);
    #1;
    reset       = rst;
    redirect    = rd;
    redirect_pc = rpc;
    mem_gnt     = int'($urandom_range(99)) < gnt_pct;
    instr_ready = int'($urandom_range(99)) < rdy_pct;
    mem_rvalid  = 1'b0;
    mem_rdata   = $urandom;
    if (!rst) begin
      pend_q.delete();
      last_due = cyc;
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(p.addr);
    end
    @(negedge clk);
    #1;
    if (!rst) begin
      exp_q.delete();
      fexp = RST_PC;
    end else if (rd) begin
      chk1("req_during_redirect", mem_req, 1'b0);
      exp_q.delete();
      fexp = {rpc[31:2], 2'b00};
    end else if (mem_req) begin
      chk("mem_addr", mem_addr, fexp);
      if (mem_gnt) begin
        grants++;
        lat = int'($urandom_range(lat_max, lat_min));
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_q.push_back('{addr: mem_addr, due: due});
        exp_q.push_back('{pc: fexp, data: mem_word(fexp)});
        fexp = fexp + 32'd4;
        chk1("credit", exp_q.size() <= DEPTH, 1'b1);
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    repeat (3) cycle(1'b0, 1'b0, 32'h0);

    // Full-rate stream from reset release.
    for (int c = 0; c < 20; c++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (c == 0) chk1("first_req", mem_req, 1'b1);
      if (c == 1) chk1("latency_early", instr_valid, 1'b0);
      if (c >= 2) chk1("throughput", instr_valid, 1'b1);
    end

    // Core stalled straight after reset.
    repeat (2) cycle(1'b0, 1'b0, 32'h0);
    rdy_pct = 0;
    grants = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (instr_valid) chk("stall_pc", instr_pc, RST_PC);
    end
    chk1("stall_grants", grants <= DEPTH, 1'b1);
    chk1("stall_req_low", mem_req, 1'b0);
    rdy_pct = 100;
    run(10);

    // Random grant and latency.
    gnt_pct = 50; lat_min = 1; lat_max = 4; rdy_pct = 70;
    run(400);

    // Redirects with responses in flight, misaligned, back to back.
    gnt_pct = 100; lat_min = 2; lat_max = 2; rdy_pct = 100;
    run(8);
    cycle(1'b1, 1'b1, 32'h0000_0100);
    run(10);
    cycle(1'b1, 1'b1, 32'h0000_0203);
    run(10);
    cycle(1'b1, 1'b1, 32'h0000_0400);
    cycle(1'b1, 1'b1, 32'h0000_0500);
    run(10);
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
    run(10);

    // Reset in the middle of a stream.
    run(6);
    cycle(1'b0, 1'b0, 32'h0);
    run(12);

    // Random mix of everything.
    gnt_pct = 60; lat_min = 1; lat_max = 4; rdy_pct = 60;
    for (int c = 0; c < 1500; c++) begin
      cycle($urandom_range(199) != 0,
            $urandom_range(29) == 0,
            $urandom);
    end
    run(10);

    chk1("progress", pops > 500, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
